// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: ID-stage operand forwarding, load-use stall and branch flush
module fwd_hazard_unit #(
  parameter int AW = 5,
  parameter int DEPTH = 3,
  parameter int LOAD_LAT = 1,
  parameter int CW = 16,
  localparam int FW = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          id_valid_i,
  input  logic [AW-1:0] id_rs_i,
  input  logic [AW-1:0] id_rt_i,
  input  logic          id_use_rs_i,
  input  logic          id_use_rt_i,
  input  logic          id_wr_en_i,
  input  logic [AW-1:0] id_wr_addr_i,
  input  logic          id_is_load_i,
  input  logic          br_taken_i,
  output logic          stall_o,
  output logic          flush_o,
  output logic [FW-1:0] fwd_a_o,
  output logic [FW-1:0] fwd_b_o,
  output logic [CW-1:0] stall_cnt_o
);
  logic [DEPTH:1] v_q, we_q, ld_q;
  logic [AW-1:0]  addr_q [1:DEPTH];
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           haz_a, haz_b, issue;

  // Scans oldest to youngest so the youngest matching producer is the one left standing.
  // Returns {load-latency hazard, stage index}.
  function automatic logic [FW:0] pick(input logic [AW-1:0] s, input logic use_s);
    logic [FW:0] r;
    r = '0;
    for (int k = DEPTH; k >= 1; k--)
      if (v_q[k] && we_q[k] && addr_q[k] == s && s != '0 && use_s)
        r = {ld_q[k] && k <= LOAD_LAT, FW'(k)};
    return r;
  endfunction

  // Per-operand forward select and hazard flag from the tracker contents.
  always_comb begin
    {haz_a, fwd_a_o} = pick(id_rs_i, id_use_rs_i);
    {haz_b, fwd_b_o} = pick(id_rt_i, id_use_rt_i);
  end

  assign flush_o     = rst_ni && br_taken_i;
  assign stall_o     = id_valid_i && !br_taken_i && (haz_a || haz_b);
  assign issue       = id_valid_i && !stall_o && !br_taken_i;
  assign cnt_d       = (stall_o && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
  assign stall_cnt_o = cnt_q;

  // Advance the in-flight tracker one stage per cycle; stalls and flushes insert a bubble.
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      v_q   <= '0;
      we_q  <= '0;
      ld_q  <= '0;
      cnt_q <= '0;
      for (int k = 1; k <= DEPTH; k++) addr_q[k] <= '0;
    end else begin
      v_q   <= (v_q << 1) | DEPTH'(issue);
      we_q  <= (we_q << 1) | DEPTH'(id_wr_en_i);
      ld_q  <= (ld_q << 1) | DEPTH'(id_is_load_i);
      cnt_q <= cnt_d;
      for (int k = DEPTH; k >= 2; k--) addr_q[k] <= addr_q[k-1];
      addr_q[1] <= id_wr_addr_i;
    end
endmodule
